ddr_cmd_sequencer: RTL and testbench

Closed-page DDR command sequencer. Accepts one file-level command (FILE_CMD encoding: NOP1/SCR/SCW/BLR/BLW/ATR/ATW/NOP2) per handshake and expands it into a timed DDR_CMD stream: ACTIVATE → column command(s) → PRECHRG, with NOP_DDR fill. It sits between the command-file front end and the DDR pin driver, and owns all row/column timing.

---
 rtl/ddr_cmd_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_ddr_cmd_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_cmd_sequencer.sv
// ddr_cmd_sequencer: closed-page DDR command sequencer.
//
// Takes one file-level command per handshake and expands it into a timed DDR
// command stream: ACTIVATE, one or more column commands, then PRECHRG. NOP_DDR
// fills every cycle in between. All outputs are registered.
//
// Ports:
//   clk, reset              single rising-edge clock, synchronous active-high reset
//   req_valid / req_ready   request handshake (ready only while idle)
//   req_cmd                 FILE_CMD: NOP1,SCR,SCW,BLR,BLW,ATR,ATW,NOP2 = 0..7
//   req_bank/row/col        target address, captured on accept
//   ddr_cmd                 {CS#,RAS#,CAS#,WE#}
//   ddr_bank, ddr_addr      bank and row/column for the current command
//   busy                    high whenever not idle
//   done                    one-cycle pulse when a request completes
module ddr_cmd_sequencer #(
    parameter int unsigned BANK_W   = 2,
    parameter int unsigned ROW_W    = 14,
    parameter int unsigned COL_W    = 10,
    parameter int unsigned T_RCD    = 3,
    parameter int unsigned T_CCD    = 4,
    parameter int unsigned T_TURN   = 6,
    parameter int unsigned T_CP     = 4,
    parameter int unsigned T_RP     = 3,
    parameter int unsigned BLK_LEN  = 4,
    parameter int unsigned COL_STEP = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_cmd,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    output logic [3:0]        ddr_cmd,
    output logic [BANK_W-1:0] ddr_bank,
    output logic [ROW_W-1:0]  ddr_addr,
    output logic              busy,
    output logic              done
);

    localparam int unsigned T_M1   = (T_RCD > T_CCD) ? T_RCD : T_CCD;
    localparam int unsigned T_M2   = (T_M1 > T_TURN) ? T_M1 : T_TURN;
    localparam int unsigned T_M3   = (T_M2 > T_CP) ? T_M2 : T_CP;
    localparam int unsigned T_MAX  = (T_M3 > T_RP) ? T_M3 : T_RP;
    localparam int unsigned WAIT_W = $clog2(T_MAX) + 1;
    localparam int unsigned BEAT_W = $clog2(BLK_LEN) + 1;

    // Wait counter reload values: a delay of T cycles leaves T-1 NOP cycles.
    localparam logic [WAIT_W-1:0] LdRcd  = WAIT_W'(T_RCD - 1);
    localparam logic [WAIT_W-1:0] LdCcd  = WAIT_W'(T_CCD - 1);
    localparam logic [WAIT_W-1:0] LdTurn = WAIT_W'(T_TURN - 1);
    localparam logic [WAIT_W-1:0] LdCp   = WAIT_W'(T_CP - 1);
    localparam logic [WAIT_W-1:0] LdRp   = WAIT_W'(T_RP - 1);

    localparam logic [3:0] DdrNop   = 4'b0111;
    localparam logic [3:0] DdrAct   = 4'b0011;
    localparam logic [3:0] DdrRead  = 4'b0101;
    localparam logic [3:0] DdrWrite = 4'b0100;
    localparam logic [3:0] DdrPre   = 4'b0010;

    localparam logic [2:0] FcNop1 = 3'd0;
    localparam logic [2:0] FcScr  = 3'd1;
    localparam logic [2:0] FcBlr  = 3'd3;
    localparam logic [2:0] FcBlw  = 3'd4;
    localparam logic [2:0] FcAtr  = 3'd5;
    localparam logic [2:0] FcAtw  = 3'd6;
    localparam logic [2:0] FcNop2 = 3'd7;

    // Each state names what ddr_cmd shows in the current cycle.
    typedef enum logic [2:0] {
        StIdle, StAct, StWaitRcd, StCol, StWaitGap, StPre, StWaitRp
    } state_e;

    state_e            state_q;
    logic [2:0]        cmd_q;
    logic [COL_W-1:0]  col_q;
    logic [WAIT_W-1:0] wait_q;
    logic [BEAT_W-1:0] beats_q;   // column commands still to issue after the current one

    logic              is_block;
    logic              is_atomic;
    logic              first_read;
    logic              next_read;
    logic [BEAT_W-1:0] first_left;
    logic [WAIT_W-1:0] gap_ld;
    logic [COL_W-1:0]  next_col;
    logic              req_is_nop;

    always_comb begin
        is_block   = (cmd_q == FcBlr) || (cmd_q == FcBlw);
        is_atomic  = (cmd_q == FcAtr) || (cmd_q == FcAtw);
        first_read = (cmd_q == FcScr) || (cmd_q == FcBlr) || (cmd_q == FcAtr);
        // Atomic ops flip direction on the second beat; block ops keep it.
        next_read  = is_atomic ? !first_read : first_read;
        first_left = is_block ? BEAT_W'(BLK_LEN - 1) : (is_atomic ? BEAT_W'(1) : '0);
        gap_ld     = is_block ? LdCcd : LdTurn;
        // Carry out of the column is dropped so bursts wrap within the row.
        next_col   = is_block ? col_q + COL_W'(COL_STEP) : col_q;
        req_is_nop = (req_cmd == FcNop1) || (req_cmd == FcNop2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cmd_q     <= FcNop1;
            col_q     <= '0;
            wait_q    <= '0;
            beats_q   <= '0;
            req_ready <= 1'b0;
            ddr_cmd   <= DdrNop;
            ddr_bank  <= '0;
            ddr_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done     <= 1'b0;
            ddr_cmd  <= DdrNop;
            ddr_addr <= '0;
            unique case (state_q)
                StIdle: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        cmd_q <= req_cmd;
                        col_q <= req_col;
                        if (req_is_nop) begin
                            done <= 1'b1;
                        end else begin
                            state_q   <= StAct;
                            ddr_cmd   <= DdrAct;
                            ddr_bank  <= req_bank;
                            ddr_addr  <= req_row;
                            busy      <= 1'b1;
                            req_ready <= 1'b0;
                            wait_q    <= LdRcd;
                        end
                    end
                end
                StAct, StWaitRcd: begin
                    if (wait_q == '0) begin
                        state_q  <= StCol;
                        ddr_cmd  <= first_read ? DdrRead : DdrWrite;
                        ddr_addr <= ROW_W'(col_q);
                        beats_q  <= first_left;
                        wait_q   <= (first_left != '0) ? gap_ld : LdCp;
                    end else begin
                        state_q <= StWaitRcd;
                        wait_q  <= wait_q - 1'b1;
                    end
                end
                StCol, StWaitGap: begin
                    if (wait_q != '0) begin
                        state_q <= StWaitGap;
                        wait_q  <= wait_q - 1'b1;
                    end else if (beats_q != '0) begin
                        state_q  <= StCol;
                        ddr_cmd  <= next_read ? DdrRead : DdrWrite;
                        ddr_addr <= ROW_W'(next_col);
                        col_q    <= next_col;
                        beats_q  <= beats_q - 1'b1;
                        wait_q   <= (beats_q > BEAT_W'(1)) ? gap_ld : LdCp;
                    end else begin
                        state_q <= StPre;
                        ddr_cmd <= DdrPre;
                        wait_q  <= LdRp;
                    end
                end
                StPre, StWaitRp: begin
                    if (wait_q == '0) begin
                        state_q   <= StIdle;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        ddr_bank  <= '0;
                    end else begin
                        state_q <= StWaitRp;
                        wait_q  <= wait_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Self-checking bench for ddr_cmd_sequencer: a per-cycle expectation table is
// built from each accepted request, and every cycle is compared against it.
module tb_ddr_cmd_sequencer;

    localparam int BANK_W   = 2;
    localparam int ROW_W    = 14;
    localparam int COL_W    = 10;
    localparam int T_RCD    = 3;
    localparam int T_CCD    = 4;
    localparam int T_TURN   = 6;
    localparam int T_CP     = 4;
    localparam int T_RP     = 3;
    localparam int BLK_LEN  = 4;
    localparam int COL_STEP = 8;
    localparam int NC       = 2600;
    localparam int RUN_END  = 2450;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] ACT = 4'b0011;
    localparam logic [3:0] RD  = 4'b0101;
    localparam logic [3:0] WR  = 4'b0100;
    localparam logic [3:0] PRE = 4'b0010;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_cmd;
    logic [BANK_W-1:0] req_bank;
    logic [ROW_W-1:0]  req_row;
    logic [COL_W-1:0]  req_col;
    logic [3:0]        ddr_cmd;
    logic [BANK_W-1:0] ddr_bank;
    logic [ROW_W-1:0]  ddr_addr;
    logic              busy;
    logic              done;

    ddr_cmd_sequencer #(
        .BANK_W(BANK_W), .ROW_W(ROW_W), .COL_W(COL_W), .T_RCD(T_RCD), .T_CCD(T_CCD),
        .T_TURN(T_TURN), .T_CP(T_CP), .T_RP(T_RP), .BLK_LEN(BLK_LEN), .COL_STEP(COL_STEP)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
        .ddr_cmd(ddr_cmd), .ddr_bank(ddr_bank), .ddr_addr(ddr_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit acc_flag = 1'b0;
    int acc_cyc = 0;

    // Expected outputs per cycle.
    logic [3:0]        exp_cmd  [NC];
    logic [ROW_W-1:0]  exp_addr [NC];
    logic [BANK_W-1:0] exp_bank [NC];
    bit                exp_bchk [NC];
    bit                exp_busy [NC];
    bit                exp_done [NC];
    bit                exp_ready[NC];

    // Observed outputs per cycle, for the hand-computed checks at the end.
    logic [3:0]        obs_cmd  [NC];
    logic [ROW_W-1:0]  obs_addr [NC];
    logic [BANK_W-1:0] obs_bank [NC];
    logic              obs_busy [NC];
    logic              obs_done [NC];
    logic              obs_ready[NC];

    function automatic void check(string name, int c, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, expv);
        end
    endfunction

    function automatic void set_default(int k);
        if (k < NC) begin
            exp_cmd[k]   = NOP;
            exp_addr[k]  = '0;
            exp_bank[k]  = '0;
            exp_bchk[k]  = 1'b0;
            exp_busy[k]  = 1'b0;
            exp_done[k]  = 1'b0;
            exp_ready[k] = 1'b1;
        end
    endfunction

    function automatic void put(int k, logic [3:0] c, int addr, int bank);
        if (k < NC) begin
            exp_cmd[k]  = c;
            exp_addr[k] = ROW_W'(addr);
            exp_bank[k] = BANK_W'(bank);
            exp_bchk[k] = 1'b1;
        end
    endfunction

    // Timeline of one request accepted in cycle c.
    function automatic void schedule(int c, int cmd, int bank, int row, int col);
        int t_col;
        int last;
        int pre;
        int dn;
        if (cmd == 0 || cmd == 7) begin
            if (c + 1 < NC) exp_done[c+1] = 1'b1;
            return;
        end
        put(c + 1, ACT, row, bank);
        t_col = c + 1 + T_RCD;
        last  = t_col;
        case (cmd)
            1: put(t_col, RD, col, bank);
            2: put(t_col, WR, col, bank);
            3, 4: begin
                for (int k = 0; k < BLK_LEN; k++)
                    put(t_col + k * T_CCD, (cmd == 3) ? RD : WR,
                        (col + k * COL_STEP) % (1 << COL_W), bank);
                last = t_col + (BLK_LEN - 1) * T_CCD;
            end
            5: begin
                put(t_col, RD, col, bank);
                put(t_col + T_TURN, WR, col, bank);
                last = t_col + T_TURN;
            end
            default: begin
                put(t_col, WR, col, bank);
                put(t_col + T_TURN, RD, col, bank);
                last = t_col + T_TURN;
            end
        endcase
        pre = last + T_CP;
        put(pre, PRE, 0, bank);
        dn = pre + T_RP;
        for (int k = c + 1; k < dn && k < NC; k++) begin
            exp_busy[k]  = 1'b1;
            exp_ready[k] = 1'b0;
        end
        if (dn < NC) exp_done[dn] = 1'b1;
    endfunction

    // Apply the current inputs to the model for this cycle, then advance one cycle.
    task automatic tick();
        if (reset) begin
            for (int k = cyc + 1; k < NC; k++) set_default(k);
            if (cyc + 1 < NC) begin
                exp_ready[cyc+1] = 1'b0;
                exp_bchk[cyc+1]  = 1'b1;
            end
        end else if (req_valid && cyc < NC && exp_ready[cyc]) begin
            acc_flag = 1'b1;
            acc_cyc  = cyc;
            schedule(cyc, int'(req_cmd), int'(req_bank), int'(req_row), int'(req_col));
        end
        cyc++;
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int cmd, input int bank, input int row, input int col,
                         output int a);
        int n;
        n = 0;
        req_cmd   = 3'(cmd);
        req_bank  = BANK_W'(bank);
        req_row   = ROW_W'(row);
        req_col   = COL_W'(col);
        req_valid = 1'b1;
        acc_flag  = 1'b0;
        while (!acc_flag && n < 200) begin
            tick();
            n++;
        end
        if (!acc_flag) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout cycle %0d: waited %0d cycles, required an accept", cyc, n);
        end
        a = acc_cyc;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Single compare process: every cycle against the model table.
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < NC) begin
            obs_cmd[cyc]   = ddr_cmd;
            obs_addr[cyc]  = ddr_addr;
            obs_bank[cyc]  = ddr_bank;
            obs_busy[cyc]  = busy;
            obs_done[cyc]  = done;
            obs_ready[cyc] = req_ready;
            check("ddr_cmd", cyc, 32'(ddr_cmd), 32'(exp_cmd[cyc]));
            check("ddr_addr", cyc, 32'(ddr_addr), 32'(exp_addr[cyc]));
            check("busy", cyc, 32'(busy), 32'(exp_busy[cyc]));
            check("done", cyc, 32'(done), 32'(exp_done[cyc]));
            check("req_ready", cyc, 32'(req_ready), 32'(exp_ready[cyc]));
            if (exp_bchk[cyc]) check("ddr_bank", cyc, 32'(ddr_bank), 32'(exp_bank[cyc]));
        end
    end

    int a1, a2, a3, a4, a5, a6, a7;
    int cnt_done, cnt_act, cnt_cmd;
    logic [2:0]        p_cmd;
    logic [BANK_W-1:0] p_bank;
    logic [ROW_W-1:0]  p_row;
    logic [COL_W-1:0]  p_col;

    initial begin
        for (int k = 0; k < NC; k++) set_default(k);
        reset     = 1'b1;
        req_valid = 1'b0;
        req_cmd   = '0;
        req_bank  = '0;
        req_row   = '0;
        req_col   = '0;
        repeat (3) tick();
        reset = 1'b0;
        idle(3);

        // SCR, with valid toggling and row changing while busy.
        issue(1, 1, 'h0123, 'h010, a1);
        while (cyc < a1 + 10) begin
            req_valid = 1'($urandom_range(0, 1));
            req_row   = ROW_W'($urandom);
            tick();
        end
        idle(4);

        issue(4, 2, 'h3FFF, 'h3F0, a2);
        idle(25);
        issue(5, 3, 'h0AAA, 'h055, a3);
        idle(19);
        issue(6, 0, 'h1000, 'h055, a4);
        idle(19);

        // NOP1 followed immediately by a held SCW.
        issue(0, 0, 0, 0, a5);
        issue(2, 1, 'h0200, 'h3FF, a6);
        idle(14);

        // Reset in the middle of a BLR.
        issue(3, 1, 'h0055, 'h100, a7);
        req_valid = 1'b0;
        while (cyc < a7 + 6) tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        idle(20);

        // Randomized traffic.
        acc_flag = 1'b1;
        while (cyc < RUN_END) begin
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) tick();
                reset = 1'b0;
            end
            if (acc_flag) begin
                p_cmd    = 3'($urandom_range(0, 7));
                p_bank   = BANK_W'($urandom);
                p_row    = ROW_W'($urandom);
                p_col    = COL_W'($urandom);
                acc_flag = 1'b0;
            end
            req_valid = ($urandom_range(0, 3) != 0);
            if (req_valid) begin
                req_cmd  = p_cmd;
                req_bank = p_bank;
                req_row  = p_row;
                req_col  = p_col;
            end else begin
                req_cmd  = 3'($urandom);
                req_bank = BANK_W'($urandom);
                req_row  = ROW_W'($urandom);
                req_col  = COL_W'($urandom);
            end
            tick();
        end
        idle(40);

        // Hand-computed expectations.
        check("lit_rst_ready", 2, 32'(obs_ready[2]), 32'h0);
        check("lit_rst_ready_rise", 4, 32'(obs_ready[4]), 32'h1);
        check("lit_scr_act", a1 + 1, 32'(obs_cmd[a1+1]), 32'(ACT));
        check("lit_scr_row", a1 + 1, 32'(obs_addr[a1+1]), 32'h0123);
        check("lit_scr_bank", a1 + 1, 32'(obs_bank[a1+1]), 32'h1);
        check("lit_scr_read", a1 + 4, 32'(obs_cmd[a1+4]), 32'(RD));
        check("lit_scr_col", a1 + 4, 32'(obs_addr[a1+4]), 32'h010);
        check("lit_scr_pre", a1 + 8, 32'(obs_cmd[a1+8]), 32'(PRE));
        check("lit_scr_done", a1 + 11, 32'(obs_done[a1+11]), 32'h1);
        check("lit_scr_ready", a1 + 11, 32'(obs_ready[a1+11]), 32'h1);
        cnt_done = 0;
        cnt_act  = 0;
        for (int k = a1 + 1; k <= a1 + 13; k++) begin
            if (obs_done[k] === 1'b1) cnt_done++;
            if (obs_cmd[k] === ACT) cnt_act++;
        end
        check("lit_scr_one_done", a1, 32'(cnt_done), 32'd1);
        check("lit_scr_one_act", a1, 32'(cnt_act), 32'd1);

        check("lit_blw_w0", a2 + 4, {obs_cmd[a2+4], 14'(obs_addr[a2+4])}, {WR, 14'h3F0});
        check("lit_blw_w1", a2 + 8, {obs_cmd[a2+8], 14'(obs_addr[a2+8])}, {WR, 14'h3F8});
        check("lit_blw_w2", a2 + 12, {obs_cmd[a2+12], 14'(obs_addr[a2+12])}, {WR, 14'h000});
        check("lit_blw_w3", a2 + 16, {obs_cmd[a2+16], 14'(obs_addr[a2+16])}, {WR, 14'h008});
        check("lit_blw_pre", a2 + 20, 32'(obs_cmd[a2+20]), 32'(PRE));
        check("lit_blw_done", a2 + 23, 32'(obs_done[a2+23]), 32'h1);

        check("lit_atr_rd", a3 + 4, {obs_cmd[a3+4], 14'(obs_addr[a3+4])}, {RD, 14'h055});
        check("lit_atr_wr", a3 + 10, {obs_cmd[a3+10], 14'(obs_addr[a3+10])}, {WR, 14'h055});
        check("lit_atr_pre", a3 + 14, 32'(obs_cmd[a3+14]), 32'(PRE));
        check("lit_atr_done", a3 + 17, 32'(obs_done[a3+17]), 32'h1);
        check("lit_atw_wr", a4 + 4, 32'(obs_cmd[a4+4]), 32'(WR));
        check("lit_atw_rd", a4 + 10, 32'(obs_cmd[a4+10]), 32'(RD));
        check("lit_atw_done", a4 + 17, 32'(obs_done[a4+17]), 32'h1);

        check("lit_nop_done", a5 + 1, 32'(obs_done[a5+1]), 32'h1);
        check("lit_nop_quiet", a5 + 1, 32'(obs_cmd[a5+1]), 32'(NOP));
        check("lit_nop_ready", a5 + 1, 32'(obs_ready[a5+1]), 32'h1);
        check("lit_scw_act", a5 + 2, 32'(obs_cmd[a5+2]), 32'(ACT));

        check("lit_blr_rd0", a7 + 4, 32'(obs_cmd[a7+4]), 32'(RD));
        check("lit_rst_nop", a7 + 7, 32'(obs_cmd[a7+7]), 32'(NOP));
        check("lit_rst_busy", a7 + 7, 32'(obs_busy[a7+7]), 32'h0);
        check("lit_rst_rdy0", a7 + 7, 32'(obs_ready[a7+7]), 32'h0);
        check("lit_rst_rdy1", a7 + 8, 32'(obs_ready[a7+8]), 32'h0);
        check("lit_rst_rdy2", a7 + 9, 32'(obs_ready[a7+9]), 32'h1);
        cnt_cmd = 0;
        for (int k = a7 + 7; k <= a7 + 20; k++)
            if (obs_cmd[k] !== NOP) cnt_cmd++;
        check("lit_rst_no_cmds", a7 + 7, 32'(cnt_cmd), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
